// File: rtl/pipe_reg_chain.sv
// Generic DEPTH-stage pipeline register chain with global stall, per-stage flush,
// load-use bubble injection, valid/ready at both ends and retire/flush counters.
module pipe_reg_chain #(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 4,
  parameter int BUBBLE_STAGE = 1,
  parameter int CNT_W        = 32
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       stall,
  input  logic                       bubble,
  input  logic [DEPTH-1:0]           flush,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           retired_cnt,
  output logic [CNT_W-1:0]           flushed_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      acc = acc + {{(OCC_W-1){1'b0}}, v[i]};
    end
    return acc;
  endfunction

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0] flushed_cnt_q, flushed_cnt_d;

  logic             adv_s;
  logic             in_ready_s;
  logic             take_s;
  logic             retire_s;
  logic [DEPTH-1:0] cand_valid_s;
  logic [WIDTH-1:0] cand_data_s [DEPTH];

  // Handshake terms and the candidate next content of every stage before flush.
  always_comb begin
    adv_s      = !stall && (!valid_q[DEPTH-1] || out_ready);
    in_ready_s = !reset_b && adv_s && !bubble;
    take_s     = in_valid && in_ready_s;
    retire_s   = valid_q[DEPTH-1] && out_ready && !stall;

    // Stage 0 always sits below the bubble stage, so a bubble only holds it.
    if (adv_s && !bubble) begin
      cand_valid_s[0] = take_s;
      cand_data_s[0]  = in_data;
    end else begin
      cand_valid_s[0] = valid_q[0];
      cand_data_s[0]  = data_q[0];
    end

    for (int i = 1; i < DEPTH; i++) begin
      if (!adv_s) begin
        cand_valid_s[i] = valid_q[i];
        cand_data_s[i]  = data_q[i];
      end else if (bubble && (i < BUBBLE_STAGE)) begin
        cand_valid_s[i] = valid_q[i];
        cand_data_s[i]  = data_q[i];
      end else if (bubble && (i == BUBBLE_STAGE)) begin
        cand_valid_s[i] = 1'b0;
        cand_data_s[i]  = '0;
      end else begin
        cand_valid_s[i] = valid_q[i-1];
        cand_data_s[i]  = data_q[i-1];
      end
    end
  end

  // Apply flush to the candidates and derive occupancy and counter updates.
  always_comb begin
    valid_d = cand_valid_s & ~flush;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = cand_data_s[i];
    end
    occ_d         = popcount(valid_d);
    retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, retire_s};
    flushed_cnt_d = flushed_cnt_q
                  + {{(CNT_W-OCC_W){1'b0}}, popcount(cand_valid_s & flush)};
  end

  // Stage, occupancy and counter registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      valid_q       <= '0;
      occ_q         <= '0;
      retired_cnt_q <= '0;
      flushed_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      occ_q         <= occ_d;
      retired_cnt_q <= retired_cnt_d;
      flushed_cnt_q <= flushed_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = valid_q[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign stage_valid = valid_q;
  assign occupancy   = occ_q;
  assign retired_cnt = retired_cnt_q;
  assign flushed_cnt = flushed_cnt_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (DEPTH=4, BUBBLE_STAGE=1, 4-bit counters so wrap is reachable).
module tb_pipe_reg_chain;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             stall;
  logic             bubble;
  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] stage_valid;
  logic [2:0]       occupancy;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] flushed_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_reg_chain #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BUBBLE_STAGE(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_b(reset_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall(stall), .bubble(bubble), .flush(flush),
    .stage_valid(stage_valid), .occupancy(occupancy),
    .retired_cnt(retired_cnt), .flushed_cnt(flushed_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] e;
    clk = 1'b0; reset_b = 1'b1; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; stall = 1'b0; bubble = 1'b0; flush = '0;

    // reset
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(stage_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ret", 64'(retired_cnt), 64'd0);
    chk("rst_fl", 64'(flushed_cnt), 64'd0);
    reset_b = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    step();

    // 1: stream 1..8, first output after the 4th edge
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = WIDTH'(k);
      step();
      e = (k >= 4) ? 64'(k - 3) : 64'd0;
      chk("s1_out_data", 64'(out_data), e);
      chk("s1_out_valid", 64'(out_valid), (k >= 4) ? 64'd1 : 64'd0);
    end
    in_valid = 1'b0; in_data = '0;
    for (int k = 9; k <= 12; k++) begin
      step();
      e = (k <= 11) ? 64'(k - 3) : 64'd0;
      chk("s1_drain_data", 64'(out_data), e);
      chk("s1_drain_valid", 64'(out_valid), (k <= 11) ? 64'd1 : 64'd0);
    end
    chk("s1_ret", 64'(retired_cnt), 64'd8);
    chk("s1_occ", 64'(occupancy), 64'd0);

    // 2: stall for 3 cycles with three entries in flight
    in_valid = 1'b1;
    in_data = 16'h0011; step();
    in_data = 16'h0012; step();
    in_data = 16'h0013; step();
    stall = 1'b1; in_data = 16'h0014;
    #1;
    chk("s2_in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("s2_valid", 64'(stage_valid), 64'h7);
      chk("s2_ret", 64'(retired_cnt), 64'd8);
    end
    stall = 1'b0;
    step();
    chk("s2_full", 64'(stage_valid), 64'hF);
    chk("s2_out", 64'(out_data), 64'h0011);
    chk("s2_occ", 64'(occupancy), 64'd4);

    // 3: bubble with A=14,B=13,C=12,D=11
    bubble = 1'b1; in_data = 16'h0015;
    #1;
    chk("s3_in_ready", 64'(in_ready), 64'd0);
    step();
    bubble = 1'b0;
    chk("s3_valid", 64'(stage_valid), 64'hD);
    chk("s3_out", 64'(out_data), 64'h0012);
    chk("s3_ret", 64'(retired_cnt), 64'd9);
    chk("s3_occ", 64'(occupancy), 64'd3);
    step();
    chk("s3_after_valid", 64'(stage_valid), 64'hB);
    chk("s3_after_out", 64'(out_data), 64'h0013);

    // 4: flush stages 0,1 while full and taking
    in_data = 16'h0016; step();
    in_data = 16'h0017; step();
    chk("s4_full", 64'(stage_valid), 64'hF);
    chk("s4_pre_out", 64'(out_data), 64'h0014);
    flush = 4'b0011; in_data = 16'h0018;
    step();
    flush = 4'b0000;
    chk("s4_valid", 64'(stage_valid), 64'hC);
    chk("s4_fl", 64'(flushed_cnt), 64'd2);
    chk("s4_out", 64'(out_data), 64'h0015);
    chk("s4_ret", 64'(retired_cnt), 64'd12);

    // 5: backpressure on a full chain
    in_data = 16'h0019; step();
    in_data = 16'h001A; step();
    in_data = 16'h001B; step();
    in_data = 16'h001C; step();
    chk("s5_full", 64'(stage_valid), 64'hF);
    chk("s5_ret_pre", 64'(retired_cnt), 64'd14);
    out_ready = 1'b0; in_data = 16'h001D;
    #1;
    chk("s5_in_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("s5_occ", 64'(occupancy), 64'd4);
      chk("s5_out", 64'(out_data), 64'h0019);
      chk("s5_ret", 64'(retired_cnt), 64'd14);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    chk("s5_resume_ready", 64'(in_ready), 64'd1);
    step();
    chk("s5_r1_out", 64'(out_data), 64'h001A);
    chk("s5_r1_ret", 64'(retired_cnt), 64'd15);
    chk("s5_r1_valid", 64'(stage_valid), 64'hE);
    step();
    chk("s5_wrap_ret", 64'(retired_cnt), 64'd0);
    chk("s5_r2_out", 64'(out_data), 64'h001B);
    step();
    chk("s5_r3_out", 64'(out_data), 64'h001C);
    step();
    chk("s5_r4_valid", 64'(stage_valid), 64'h0);
    chk("s5_r4_ret", 64'(retired_cnt), 64'd2);

    // flush during stall counts held entries and keeps payloads
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = WIDTH'(16'h0021 + k);
      step();
    end
    chk("sf_full", 64'(stage_valid), 64'hF);
    stall = 1'b1; flush = 4'b1111; in_data = 16'h0025;
    step();
    stall = 1'b0; flush = 4'b0000;
    chk("sf_valid", 64'(stage_valid), 64'h0);
    chk("sf_fl", 64'(flushed_cnt), 64'd6);
    chk("sf_payload", 64'(out_data), 64'h0021);

    // 6: drive both counters to max, then reset mid-stream
    out_ready = 1'b1; flush = 4'b0001;
    for (int k = 0; k < 9; k++) begin
      in_data = WIDTH'(16'h0040 + k);
      step();
    end
    flush = 4'b0000;
    chk("s6_fl_max", 64'(flushed_cnt), 64'd15);
    chk("s6_fl_valid", 64'(stage_valid), 64'h0);
    for (int k = 1; k <= 14; k++) begin
      in_data = WIDTH'(16'h0030 + k);
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("s6_ret_max", 64'(retired_cnt), 64'd15);
    chk("s6_out", 64'(out_data), 64'h003E);
    in_valid = 1'b1; in_data = 16'h0055; reset_b = 1'b1;
    #1;
    chk("s6_rst_ready", 64'(in_ready), 64'd0);
    step();
    chk("s6_valid", 64'(stage_valid), 64'h0);
    chk("s6_ret", 64'(retired_cnt), 64'd0);
    chk("s6_fl", 64'(flushed_cnt), 64'd0);
    chk("s6_out_data", 64'(out_data), 64'h0);
    reset_b = 1'b0; in_valid = 1'b0;
    step();
    chk("s6_post_occ", 64'(occupancy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
